// File: rtl/muldiv_seq_if.sv
// Handshake/result bundle between the EX-stage issue logic and the mul/div sequencer.
// Ports: start/op/rs/rt/cancel flow master->slave; busy/done/div_by_zero/hi/lo flow slave->master.
// master = issuing side (pipeline or bench), slave = muldiv_seq.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, cancel,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, cancel,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit sharing one WIDTH-bit adder; results land in HI/LO.
// Latency: done in cycle N+WIDTH+5 after start at edge N (N+2 for divide by zero).
// Backpressure: busy high outside IDLE; start while busy is dropped, cancel aborts (except in DONE).
// Ports: clk, rst_n (async active-low); bus (slave modport): start/op/rs/rt/cancel in,
//        busy/done/div_by_zero/hi/lo out.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ZDIV, S_ABS_A, S_ABS_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] rs_q, rt_q, b_q, p_q, q_q, hi_q, lo_q;
  logic             sq_q, sr_q, k_q, dbz_q;
  logic [CW-1:0]    cnt_q;

  // Shared adder
  logic [WIDTH-1:0] add_a, add_b, add_s;
  logic             add_cin, add_c;
  assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  // op[1] selects divide, op[0] selects signed
  logic             is_div, is_sgn, neg_a, neg_b, neg_lo, neg_hi, div_t, kill;
  logic [WIDTH-1:0] r_sh;
  assign is_div = op_q[1];
  assign is_sgn = op_q[0];
  assign neg_a  = is_sgn & rs_q[WIDTH-1];
  assign neg_b  = is_sgn & rt_q[WIDTH-1];
  assign neg_lo = is_sgn & sq_q;
  // Remainder takes the dividend's sign, product high half the product sign
  assign neg_hi = is_sgn & (is_div ? sr_q : sq_q);
  // Divide step: {t,R,Q} = {R,Q} << 1
  assign div_t  = p_q[WIDTH-1];
  assign r_sh   = {p_q[WIDTH-2:0], q_q[WIDTH-1]};
  // Cancel is honoured in every busy state except DONE, where the result already committed
  assign kill   = bus.cancel && (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      S_ABS_A:  begin add_a = ~rs_q; add_cin = 1'b1; end
      S_ABS_B:  begin add_a = ~rt_q; add_cin = 1'b1; end
      S_ITER: begin
        if (is_div) begin
          add_a = r_sh; add_b = ~b_q; add_cin = 1'b1;
        end else begin
          add_a = p_q;  add_b = b_q;
        end
      end
      S_FIX_LO: begin add_a = ~q_q; add_cin = 1'b1; end
      // Multiply high half absorbs the carry out of the low-half negate
      S_FIX_HI: begin add_a = ~p_q; add_cin = is_div ? 1'b1 : k_q; end
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = (bus.op[1] && (bus.rt == '0)) ? S_ZDIV : S_ABS_A;
      S_ZDIV:   state_d = S_DONE;
      S_ABS_A:  state_d = S_ABS_B;
      S_ABS_B:  state_d = S_ITER;
      S_ITER:   if (cnt_q == LAST) state_d = S_FIX_LO;
      S_FIX_LO: state_d = S_FIX_HI;
      S_FIX_HI: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // P doubles as the divide remainder R; Q holds A / multiplier / quotient.
  // hi/lo are loaded on the edge into DONE so they are valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0; rs_q <= '0; rt_q <= '0; b_q <= '0;
      p_q   <= '0; q_q  <= '0; hi_q <= '0; lo_q <= '0;
      sq_q  <= 1'b0; sr_q <= 1'b0; k_q <= 1'b0; dbz_q <= 1'b0;
      cnt_q <= '0;
    end else if (!kill) begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          op_q  <= bus.op;
          rs_q  <= bus.rs;
          rt_q  <= bus.rt;
          dbz_q <= 1'b0;
        end
        S_ZDIV: begin
          hi_q  <= rs_q;
          lo_q  <= '1;
          dbz_q <= 1'b1;
        end
        S_ABS_A: begin
          q_q <= neg_a ? add_s : rs_q;
          p_q <= '0;
        end
        S_ABS_B: begin
          b_q   <= neg_b ? add_s : rt_q;
          sq_q  <= rs_q[WIDTH-1] ^ rt_q[WIDTH-1];
          sr_q  <= rs_q[WIDTH-1];
          cnt_q <= '0;
        end
        S_ITER: begin
          cnt_q <= cnt_q + CW'(1);
          if (is_div) begin
            if (add_c | div_t) begin
              p_q <= add_s;
              q_q <= {q_q[WIDTH-2:0], 1'b1};
            end else begin
              p_q <= r_sh;
              q_q <= {q_q[WIDTH-2:0], 1'b0};
            end
          end else if (q_q[0]) begin
            p_q <= {add_c, add_s[WIDTH-1:1]};
            q_q <= {add_s[0], q_q[WIDTH-1:1]};
          end else begin
            p_q <= {1'b0, p_q[WIDTH-1:1]};
            q_q <= {p_q[0], q_q[WIDTH-1:1]};
          end
        end
        S_FIX_LO: if (neg_lo) begin
          q_q <= add_s;
          k_q <= add_c;
        end
        S_FIX_HI: begin
          p_q  <= neg_hi ? add_s : p_q;
          hi_q <= neg_hi ? add_s : p_q;
          lo_q <= q_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  muldiv_seq_if #(.WIDTH(32)) bus ();
  muldiv_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and return at the negedge where done is seen (or the bound expires)
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs = a; bus.rt = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!bus.busy) busy_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    logic bok;
    int   cyc;
    int   ndone;

    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 37};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 37};
    vecs[2]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 37};
    vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 37};
    vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 37};
    vecs[5]  = '{DIVU,  32'h0000002A, 32'h00000000, 32'h0000002A, 32'hFFFFFFFF, 1'b1, 2};
    vecs[6]  = '{DIVU,  32'h0000002A, 32'h00000005, 32'h00000002, 32'h00000008, 1'b0, 37};
    vecs[7]  = '{MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, 37};
    vecs[8]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 37};
    vecs[9]  = '{MULTU, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 37};
    vecs[10] = '{DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 37};
    vecs[11] = '{MULT,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 37};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs = '0; bus.rt = '0; bus.cancel = 1'b0;
    #23;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz",  bus.div_by_zero, 0);
    chk("rst_hi",   bus.hi, 0);
    chk("rst_lo",   bus.lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, bok);
      chk($sformatf("v%0d_lat", i),  lat, vecs[i].lat);
      chk($sformatf("v%0d_busy", i), bok, 1);
      chk($sformatf("v%0d_hi", i),   bus.hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i),   bus.lo, vecs[i].lo);
      chk($sformatf("v%0d_dbz", i),  bus.div_by_zero, vecs[i].dbz);
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), {bus.busy, bus.done}, 0);
    end

    // Second start while busy must be ignored (a divide-by-zero would be visible)
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULTU; bus.rs = 32'd3; bus.rt = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      if (cyc == 5) begin
        bus.start = 1'b1; bus.op = DIVU; bus.rs = 32'd9; bus.rt = 32'd0;
      end else begin
        bus.start = 1'b0; bus.op = MULTU;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("ign_lat", cyc, 37);
    chk("ign_hi",  bus.hi, 32'h0);
    chk("ign_lo",  bus.lo, 32'hF);
    chk("ign_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    chk("ign_idle", bus.busy, 0);

    // Cancel in ITER: idle next cycle, results untouched, no done
    @(negedge clk);
    bus.start = 1'b1; bus.op = DIVU; bus.rs = 32'd100; bus.rt = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("cxl_busy_before", bus.busy, 1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cxl_idle", bus.busy, 0);
    chk("cxl_hi", bus.hi, 32'h0);
    chk("cxl_lo", bus.lo, 32'hF);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    chk("cxl_no_done", ndone, 0);
    chk("cxl_lo_after", bus.lo, 32'hF);

    // Cancel during DONE is ignored
    run_op(MULTU, 32'd6, 32'd7, lat, bok);
    chk("cdone_lat", lat, 37);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cdone_lo", bus.lo, 32'h2A);
    chk("cdone_idle", bus.busy, 0);

    // Start and cancel together in IDLE: start wins
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MULTU; bus.rs = 32'd2; bus.rt = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    chk("sc_busy", bus.busy, 1);
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("sc_lat", cyc, 37);
    chk("sc_lo", bus.lo, 32'd6);

    // Reset mid-operation clears everything without a clock edge
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULT; bus.rs = 32'd3; bus.rt = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_lo",   bus.lo, 0);
    chk("mrst_hi",   bus.hi, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unit still works after reset
    run_op(MULT, 32'd3, 32'd5, lat, bok);
    chk("post_lat", lat, 37);
    chk("post_lo", bus.lo, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
